// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the common data bus payload and the CDB arbiter configuration.
package rv32i_types;

    localparam int CDB_NUM_REQ      = 4;
    localparam int CDB_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        CDB_ALU = 2'd0,
        CDB_MUL = 2'd1,
        CDB_DIV = 2'd2,
        CDB_LSU = 2'd3
    } cdb_req_e;

    typedef struct packed {
        logic        cdb_valid;
        logic [5:0]  rob_index;
        logic [6:0]  phys_rd;
        logic [31:0] data;
        logic        branch_commit;
        logic        mispredict;
    } cdb_t;

endpackage

// File: rtl/rr_find_first.sv
// Combinational wrap-around picker: one-hot of the first set bit of req at or after ptr (ptr < N).
// Zero latency, no state; rotate right by ptr, isolate the lowest set bit, rotate back.
module rr_find_first #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             found
);
    logic [N-1:0] rot;
    logic [N-1:0] iso;

    always_comb begin
        rot   = N'({req, req} >> ptr);
        iso   = rot & (~rot + N'(1));
        gnt   = N'(({iso, iso} << ptr) >> N);
        found = |req;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one FU result per cycle, starved > branch > round-robin; grant is same-cycle,
// payload is on cdb_out one cycle later. branch_flush or rst blocks all grants (req_ready=0).
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ      = CDB_NUM_REQ,
    parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_flush,
    input  logic [NUM_REQ-1:0] req_valid,
    input  cdb_t [NUM_REQ-1:0] req_cdb,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               cdb_valid,
    output cdb_t               cdb_out,
    output logic [31:0]        conflict_cycles
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                          cdb_valid_q, cdb_valid_d;
    cdb_t                          cdb_out_q, cdb_out_d;
    logic [31:0]                   conflict_q, conflict_d;

    logic [NUM_REQ-1:0] branch_mask, starve_mask, starve_oh;
    logic [NUM_REQ-1:0] branch_oh, rr_oh, grant_oh;
    logic               branch_found, rr_found;
    logic [PTR_W-1:0]   grant_idx;

    always_comb begin
        branch_mask = '0;
        starve_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            branch_mask[i] = req_valid[i] & req_cdb[i].branch_commit;
            starve_mask[i] = req_valid[i] & (wait_cnt_q[i] == LIMIT);
        end
        // Lowest-index starved requester: isolate the lowest set bit.
        starve_oh = starve_mask & (~starve_mask + NUM_REQ'(1));
    end

    rr_find_first #(.N(NUM_REQ), .PTR_W(PTR_W)) u_branch_pick (
        .req   (branch_mask),
        .ptr   (rr_ptr_q),
        .gnt   (branch_oh),
        .found (branch_found)
    );

    rr_find_first #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (rr_oh),
        .found (rr_found)
    );

    always_comb begin
        grant_oh = '0;
        if (!rst && !branch_flush) begin
            if (|starve_mask) begin
                grant_oh = starve_oh;
            end else if (branch_found) begin
                grant_oh = branch_oh;
            end else if (rr_found) begin
                grant_oh = rr_oh;
            end
        end
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) grant_idx = PTR_W'(i);
        end
    end

    assign req_ready = grant_oh;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_out_d   = '0;
        if (|grant_oh) begin
            rr_ptr_d            = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            cdb_valid_d         = 1'b1;
            cdb_out_d           = req_cdb[grant_idx];
            cdb_out_d.cdb_valid = 1'b1;
        end
        wait_cnt_d = wait_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (branch_flush || !req_valid[i] || grant_oh[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != LIMIT) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end
        conflict_d = conflict_q + (($countones(req_valid) >= 2) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
            conflict_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_out_q   <= cdb_out_d;
            conflict_q  <= conflict_d;
        end
    end

    assign cdb_valid       = cdb_valid_q;
    assign cdb_out         = cdb_out_q;
    assign conflict_cycles = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N     = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [3:0]   valid = '0;
    cdb_t [3:0]   pay = '0;
    logic [3:0]   ready;
    logic         cdb_valid;
    cdb_t         cdb_out;
    logic [31:0]  conflict;

    logic         flush3 = 1'b0;
    logic [2:0]   valid3 = '0;
    cdb_t [2:0]   pay3 = '0;
    logic [2:0]   ready3;
    logic         cdb_valid3;
    cdb_t         cdb_out3;
    logic [31:0]  conflict3;

    cdb_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .branch_flush(flush), .req_valid(valid), .req_cdb(pay),
        .req_ready(ready), .cdb_valid(cdb_valid), .cdb_out(cdb_out), .conflict_cycles(conflict)
    );

    cdb_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clk(clk), .rst(rst), .branch_flush(flush3), .req_valid(valid3), .req_cdb(pay3),
        .req_ready(ready3), .cdb_valid(cdb_valid3), .cdb_out(cdb_out3), .conflict_cycles(conflict3)
    );

    int tests_run = 0;
    int fails     = 0;

    // Reference model of the 4-requester instance.
    int          m_ptr = 0;
    int          m_wait [N] = '{default: 0};
    bit          m_cdb_valid = 1'b0;
    cdb_t        m_cdb_out = '0;
    bit [31:0]   m_conflict = '0;
    int          m_grant = -1;

    function automatic cdb_t rand_cdb(bit br);
        cdb_t p;
        p.cdb_valid     = 1'($urandom);
        p.rob_index     = 6'($urandom);
        p.phys_rd       = 7'($urandom);
        p.data          = $urandom;
        p.branch_commit = br;
        p.mispredict    = br & 1'($urandom);
        return p;
    endfunction

    function automatic int m_pick();
        if (rst || flush || valid == 4'd0) return -1;
        for (int i = 0; i < N; i++)
            if (valid[i] && m_wait[i] >= LIMIT) return i;
        for (int k = 0; k < N; k++)
            if (valid[(m_ptr + k) % N] && pay[(m_ptr + k) % N].branch_commit) return (m_ptr + k) % N;
        for (int k = 0; k < N; k++)
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic void m_update();
        if (rst) begin
            m_ptr = 0;
            m_wait = '{default: 0};
            m_cdb_valid = 1'b0;
            m_cdb_out = '0;
            m_conflict = '0;
            return;
        end
        if ($countones(valid) >= 2) m_conflict = m_conflict + 1;
        for (int i = 0; i < N; i++) begin
            if (flush || !valid[i] || m_grant == i) m_wait[i] = 0;
            else if (m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
        end
        if (m_grant >= 0) begin
            m_ptr = (m_grant + 1) % N;
            m_cdb_valid = 1'b1;
            m_cdb_out = pay[m_grant];
            m_cdb_out.cdb_valid = 1'b1;
        end else begin
            m_cdb_valid = 1'b0;
            m_cdb_out = '0;
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        m_grant = m_pick();
    endtask

    task automatic advance();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 4'hF;
        valid3 = 3'b111;
        for (int i = 0; i < N; i++) pay[i] = rand_cdb(1'b0);
        settle();
        tests_run++; if (ready !== 4'd0) begin fails++; $display("FAIL reset_ready: got %b want 0000", ready); end
        advance();
        settle();
        advance();
        rst = 1'b0;
        valid = '0;
        valid3 = '0;
        tests_run++; if (cdb_valid !== 1'b0 || cdb_valid3 !== 1'b0) begin fails++; $display("FAIL reset_cdb_valid: got %b/%b want 0", cdb_valid, cdb_valid3); end
        tests_run++; if (cdb_out !== '0) begin fails++; $display("FAIL reset_cdb_out: got %h want 0", cdb_out); end
        tests_run++; if (conflict !== 32'd0) begin fails++; $display("FAIL reset_conflict: got %0d want 0", conflict); end
        tests_run++; if (dut.rr_ptr_q !== 2'd0 || dut.wait_cnt_q !== '0) begin fails++; $display("FAIL reset_state: ptr %0d wait %h want 0", dut.rr_ptr_q, dut.wait_cnt_q); end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_rob;
        exp_rob = '0;
        valid = 4'hF;
        for (int i = 0; i < N; i++) pay[i] = rand_cdb(1'b0);
        for (int c = 0; c < 8; c++) begin
            settle();
            tests_run++; if (ready !== 4'(1 << (c % 4))) begin fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, ready, 4'(1 << (c % 4))); end
            if (c > 0) begin
                tests_run++; if (cdb_valid !== 1'b1 || cdb_out.rob_index !== exp_rob) begin fails++; $display("FAIL rr_payload c%0d: got v%b rob %0d want v1 rob %0d", c, cdb_valid, cdb_out.rob_index, exp_rob); end
            end
            exp_rob = pay[c % 4].rob_index;
            advance();
            pay[c % 4] = rand_cdb(1'b0);
        end
        tests_run++; if (cdb_out.rob_index !== exp_rob || cdb_out !== m_cdb_out) begin fails++; $display("FAIL rr_last_payload: got %h want %h", cdb_out, m_cdb_out); end
        tests_run++; if (conflict !== 32'd8) begin fails++; $display("FAIL rr_conflict: got %0d want 8", conflict); end
    endtask

    task automatic test_branch_priority();
        cdb_t br_pay;
        valid = 4'b0100;
        pay[2] = rand_cdb(1'b0);
        settle();
        advance();
        tests_run++; if (dut.rr_ptr_q !== 2'd3) begin fails++; $display("FAIL br_setup_ptr: got %0d want 3", dut.rr_ptr_q); end
        valid = 4'b0101;
        pay[0] = rand_cdb(1'b0);
        pay[2] = rand_cdb(1'b1);
        br_pay = pay[2];
        settle();
        tests_run++; if (ready !== 4'b0100) begin fails++; $display("FAIL br_first: got %b want 0100", ready); end
        advance();
        valid = 4'b0001;
        settle();
        tests_run++; if (ready !== 4'b0001) begin fails++; $display("FAIL br_second: got %b want 0001", ready); end
        tests_run++; if (cdb_out.branch_commit !== 1'b1 || cdb_out.rob_index !== br_pay.rob_index || cdb_out.cdb_valid !== 1'b1) begin fails++; $display("FAIL br_payload: got %h want rob %0d", cdb_out, br_pay.rob_index); end
        advance();
    endtask

    task automatic test_starvation();
        int granted_at;
        granted_at = 0;
        valid = 4'hF;
        pay[0] = rand_cdb(1'b1);
        pay[1] = rand_cdb(1'b1);
        pay[2] = rand_cdb(1'b0);
        pay[3] = rand_cdb(1'b1);
        for (int c = 1; c <= 12 && granted_at == 0; c++) begin
            settle();
            tests_run++; if (ready !== ((m_grant >= 0) ? 4'(1 << m_grant) : 4'd0)) begin fails++; $display("FAIL starve_model c%0d: got %b want grant %0d", c, ready, m_grant); end
            if (ready[2]) granted_at = c;
            advance();
            if (m_grant >= 0 && m_grant != 2) pay[m_grant] = rand_cdb(1'b1);
        end
        tests_run++; if (granted_at !== 9) begin fails++; $display("FAIL starve_cycle: got %0d want 9", granted_at); end
        tests_run++; if (dut.wait_cnt_q[2] !== '0) begin fails++; $display("FAIL starve_wait_clear: got %0d want 0", dut.wait_cnt_q[2]); end
    endtask

    task automatic test_flush();
        int exp_ptr;
        valid = 4'b1010;
        pay[1] = rand_cdb(1'b0);
        pay[3] = rand_cdb(1'b0);
        settle();
        advance();
        pay[m_grant] = rand_cdb(1'b0);
        tests_run++; if (cdb_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_valid: got %b want 1", cdb_valid); end
        exp_ptr = m_ptr;
        flush = 1'b1;
        valid = 4'b1110;
        settle();
        tests_run++; if (ready !== 4'd0) begin fails++; $display("FAIL flush_ready: got %b want 0000", ready); end
        advance();
        tests_run++; if (cdb_valid !== 1'b0 || cdb_out !== '0) begin fails++; $display("FAIL flush_cdb: got v%b %h want 0", cdb_valid, cdb_out); end
        tests_run++; if (int'(dut.rr_ptr_q) !== exp_ptr) begin fails++; $display("FAIL flush_ptr: got %0d want %0d", dut.rr_ptr_q, exp_ptr); end
        tests_run++; if (dut.wait_cnt_q !== '0) begin fails++; $display("FAIL flush_wait: got %h want 0", dut.wait_cnt_q); end
        flush = 1'b0;
        valid = '0;
    endtask

    task automatic test_wrap3();
        for (int i = 0; i < 3; i++) pay3[i] = rand_cdb(1'b0);
        valid3 = 3'b010;
        settle();
        tests_run++; if (ready3 !== 3'b010) begin fails++; $display("FAIL wrap_setup: got %b want 010", ready3); end
        advance();
        tests_run++; if (dut3.rr_ptr_q !== 2'd2) begin fails++; $display("FAIL wrap_ptr2: got %0d want 2", dut3.rr_ptr_q); end
        valid3 = 3'b101;
        settle();
        tests_run++; if (ready3 !== 3'b100) begin fails++; $display("FAIL wrap_grant2: got %b want 100", ready3); end
        advance();
        tests_run++; if (dut3.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL wrap_ptr0: got %0d want 0", dut3.rr_ptr_q); end
        tests_run++; if (cdb_valid3 !== 1'b1 || cdb_out3.rob_index !== pay3[2].rob_index) begin fails++; $display("FAIL wrap_payload: got v%b rob %0d want rob %0d", cdb_valid3, cdb_out3.rob_index, pay3[2].rob_index); end
        valid3 = 3'b001;
        settle();
        tests_run++; if (ready3 !== 3'b001) begin fails++; $display("FAIL wrap_grant0: got %b want 001", ready3); end
        advance();
        valid3 = '0;
    endtask

    task automatic test_mid_reset();
        valid = 4'hF;
        for (int i = 0; i < N; i++) pay[i] = rand_cdb(1'($urandom));
        for (int c = 0; c < 3; c++) begin
            settle();
            advance();
            if (m_grant >= 0) pay[m_grant] = rand_cdb(1'($urandom));
        end
        rst = 1'b1;
        settle();
        tests_run++; if (ready !== 4'd0) begin fails++; $display("FAIL midrst_ready: got %b want 0000", ready); end
        advance();
        tests_run++; if (cdb_valid !== 1'b0 || conflict !== 32'd0 || dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL midrst_state: v%b conflict %0d ptr %0d want 0", cdb_valid, conflict, dut.rr_ptr_q); end
        settle();
        tests_run++; if (ready !== 4'd0) begin fails++; $display("FAIL midrst_ready_hold: got %b want 0000", ready); end
        advance();
        rst = 1'b0;
        valid = '0;
    endtask

    task automatic test_random();
        int waited [N] = '{default: 0};
        int max_wait;
        max_wait = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 2) != 0) begin
                    valid[i] = 1'b1;
                    pay[i] = rand_cdb($urandom_range(0, 3) == 0);
                end
            end
            settle();
            tests_run++; if (ready !== ((m_grant >= 0) ? 4'(1 << m_grant) : 4'd0)) begin fails++; $display("FAIL rand_grant cyc%0d: got %b want grant %0d", cyc, ready, m_grant); end
            tests_run++; if (cdb_valid !== m_cdb_valid || cdb_out !== m_cdb_out) begin fails++; $display("FAIL rand_cdb cyc%0d: got v%b %h want v%b %h", cyc, cdb_valid, cdb_out, m_cdb_valid, m_cdb_out); end
            for (int i = 0; i < N; i++) begin
                if (flush || !valid[i] || m_grant == i) waited[i] = 0;
                else waited[i] = waited[i] + 1;
                if (waited[i] > max_wait) max_wait = waited[i];
            end
            advance();
            if (m_grant >= 0) begin
                if ($urandom_range(0, 1) == 0) valid[m_grant] = 1'b0;
                else pay[m_grant] = rand_cdb($urandom_range(0, 3) == 0);
            end
        end
        flush = 1'b0;
        tests_run++; if (max_wait > LIMIT + N) begin fails++; $display("FAIL rand_starve_bound: got %0d want <= %0d", max_wait, LIMIT + N); end
        tests_run++; if (conflict !== m_conflict) begin fails++; $display("FAIL rand_conflict: got %0d want %0d", conflict, m_conflict); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_branch_priority();
        test_starvation();
        test_flush();
        test_wrap3();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
